cmul_share_arbiter: RTL and testbench

CMUL_SHARE_ARBITER -- requirements
Module: cmul_share_arbiter

---
 rtl/cmul_share_arbiter_if.sv | 50 +++++
 rtl/cmul_share_arbiter.sv | 122 ++++++++++++
 tb/tb_cmul_share_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmul_share_arbiter_if.sv
// cmul_share_arbiter_if: bundles the two requester ports, the shared
// multiplier port and the status outputs of cmul_share_arbiter.
// The arbiter connects through the master modport; the requesters and
// the multiplier together form the slave side.
interface cmul_share_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int RES_WIDTH = 2 * DATA_WIDTH + 1;

  logic                  sw_rst;

  logic                  req0_op_val, req0_op_ready;
  logic [DATA_WIDTH-1:0] req0_op_1_re, req0_op_1_im, req0_op_2_re, req0_op_2_im;
  logic                  req0_res_val, req0_res_ready;
  logic [RES_WIDTH-1:0]  req0_res_re, req0_res_im;

  logic                  req1_op_val, req1_op_ready;
  logic [DATA_WIDTH-1:0] req1_op_1_re, req1_op_1_im, req1_op_2_re, req1_op_2_im;
  logic                  req1_res_val, req1_res_ready;
  logic [RES_WIDTH-1:0]  req1_res_re, req1_res_im;

  logic                  m_sw_rst, m_op_val, m_op_ready;
  logic [DATA_WIDTH-1:0] m_op_1_re, m_op_1_im, m_op_2_re, m_op_2_im;
  logic                  m_res_val, m_res_ready;
  logic [RES_WIDTH-1:0]  m_res_re, m_res_im;

  logic                  busy, grant_id;

  modport master (
    input  sw_rst,
    input  req0_op_val, req0_op_1_re, req0_op_1_im, req0_op_2_re, req0_op_2_im, req0_res_ready,
    output req0_op_ready, req0_res_val, req0_res_re, req0_res_im,
    input  req1_op_val, req1_op_1_re, req1_op_1_im, req1_op_2_re, req1_op_2_im, req1_res_ready,
    output req1_op_ready, req1_res_val, req1_res_re, req1_res_im,
    output m_sw_rst, m_op_val, m_op_1_re, m_op_1_im, m_op_2_re, m_op_2_im, m_res_ready,
    input  m_op_ready, m_res_val, m_res_re, m_res_im,
    output busy, grant_id
  );

  modport slave (
    output sw_rst,
    output req0_op_val, req0_op_1_re, req0_op_1_im, req0_op_2_re, req0_op_2_im, req0_res_ready,
    input  req0_op_ready, req0_res_val, req0_res_re, req0_res_im,
    output req1_op_val, req1_op_1_re, req1_op_1_im, req1_op_2_re, req1_op_2_im, req1_res_ready,
    input  req1_op_ready, req1_res_val, req1_res_re, req1_res_im,
    input  m_sw_rst, m_op_val, m_op_1_re, m_op_1_im, m_op_2_re, m_op_2_im, m_res_ready,
    output m_op_ready, m_res_val, m_res_re, m_res_im,
    input  busy, grant_id
  );
endinterface

// File: rtl/cmul_share_arbiter.sv
// cmul_share_arbiter: shares one complex multiplier between two requesters,
// one transaction in flight (IDLE -> ISSUE -> WAIT_RES -> DELIVER).
// Ties are resolved round-robin; defining CMUL_ARB_FIXED_PRIO_EN makes
// requester 0 win every tie instead.
module cmul_share_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  cmul_share_arbiter_if.master bus
);
  localparam int RES_WIDTH = 2 * DATA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, DELIVER} state_t;

  state_t                state, next_state;
  logic                  owner;
`ifndef CMUL_ARB_FIXED_PRIO_EN
  logic                  last_served;
`endif
  logic [DATA_WIDTH-1:0] op_1_re, op_1_im, op_2_re, op_2_im;
  logic [RES_WIDTH-1:0]  res_re, res_im;
  logic                  grant0, grant1, owner_ready;

  assign owner_ready = owner ? bus.req1_res_ready : bus.req0_res_ready;

  // Combinational grant while idle; held off during either reset
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst && !bus.sw_rst) begin
`ifdef CMUL_ARB_FIXED_PRIO_EN
      grant0 = bus.req0_op_val;
`else
      grant0 = bus.req0_op_val && (!bus.req1_op_val || last_served);
`endif
      grant1 = bus.req1_op_val && !grant0;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (grant0 || grant1) next_state = ISSUE;
      ISSUE:    if (bus.m_op_ready)   next_state = WAIT_RES;
      WAIT_RES: if (bus.m_res_val)    next_state = DELIVER;
      DELIVER:  if (owner_ready)      next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
  end

  // State register; software reset abandons any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             state <= IDLE;
    else if (bus.sw_rst) state <= IDLE;
    else                 state <= next_state;
  end

  // Operand/owner capture on grant, result capture from the multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= 1'b0;
      op_1_re <= '0;
      op_1_im <= '0;
      op_2_re <= '0;
      op_2_im <= '0;
      res_re  <= '0;
      res_im  <= '0;
    end else if (bus.sw_rst) begin
      owner   <= 1'b0;
      op_1_re <= '0;
      op_1_im <= '0;
      op_2_re <= '0;
      op_2_im <= '0;
      res_re  <= '0;
      res_im  <= '0;
    end else begin
      if (grant0 || grant1) begin
        owner   <= grant1;
        op_1_re <= grant1 ? bus.req1_op_1_re : bus.req0_op_1_re;
        op_1_im <= grant1 ? bus.req1_op_1_im : bus.req0_op_1_im;
        op_2_re <= grant1 ? bus.req1_op_2_re : bus.req0_op_2_re;
        op_2_im <= grant1 ? bus.req1_op_2_im : bus.req0_op_2_im;
      end
      if (state == WAIT_RES && bus.m_res_val) begin
        res_re <= bus.m_res_re;
        res_im <= bus.m_res_im;
      end
    end
  end

`ifndef CMUL_ARB_FIXED_PRIO_EN
  // Round-robin history; reset value lets requester 0 win the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   last_served <= 1'b1;
    else if (bus.sw_rst)                       last_served <= 1'b1;
    else if (state == DELIVER && owner_ready)  last_served <= owner;
  end
`endif

  assign bus.req0_op_ready = grant0;
  assign bus.req1_op_ready = grant1;

  assign bus.m_sw_rst    = bus.sw_rst;
  assign bus.m_op_val    = (state == ISSUE);
  assign bus.m_op_1_re   = op_1_re;
  assign bus.m_op_1_im   = op_1_im;
  assign bus.m_op_2_re   = op_2_re;
  assign bus.m_op_2_im   = op_2_im;
  assign bus.m_res_ready = (state == WAIT_RES);

  assign bus.req0_res_val = (state == DELIVER) && !owner;
  assign bus.req1_res_val = (state == DELIVER) && owner;
  assign bus.req0_res_re  = res_re;
  assign bus.req0_res_im  = res_im;
  assign bus.req1_res_re  = res_re;
  assign bus.req1_res_im  = res_im;

  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = owner;
endmodule

// File: tb/tb_cmul_share_arbiter.sv
// tb_cmul_share_arbiter: scoreboard bench for cmul_share_arbiter with a
// behavioural shared multiplier, per-requester drivers and a result monitor.
module tb_cmul_share_arbiter;
  localparam int DW = 8;
  localparam int RW = 2 * DW + 1;

  typedef struct packed {
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  } op_t;
  typedef struct packed {
    logic signed [RW-1:0] re, im;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sw  = 1'b0;
  always #5 clk = ~clk;

  cmul_share_arbiter_if #(.DATA_WIDTH(DW)) bus ();
  cmul_share_arbiter #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Complex product straight from (a+bj)(c+dj) = (ac-bd) + (ad+bc)j
  function automatic res_t cmul(input op_t o);
    res_t r;
    int re, im;
    re = int'($signed(o.a_re)) * int'($signed(o.b_re)) - int'($signed(o.a_im)) * int'($signed(o.b_im));
    im = int'($signed(o.a_re)) * int'($signed(o.b_im)) + int'($signed(o.a_im)) * int'($signed(o.b_re));
    r.re = RW'(re);
    r.im = RW'(im);
    return r;
  endfunction

  function automatic op_t mk_op(input int a, input int b, input int c, input int d);
    op_t o;
    o.a_re = DW'(a); o.a_im = DW'(b); o.b_re = DW'(c); o.b_im = DW'(d);
    return o;
  endfunction

  function automatic op_t rand_op();
    return mk_op(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
  endfunction

  // Requester side
  logic [1:0]    op_val   = 2'b00;
  logic [1:0]    res_rdy  = 2'b11;
  logic [1:0]    op_rdy, res_val;
  op_t           op_d [2] = '{default: '0};
  logic [RW-1:0] res_re [2];
  logic [RW-1:0] res_im [2];

  assign bus.sw_rst         = sw;
  assign bus.req0_op_val    = op_val[0];
  assign bus.req1_op_val    = op_val[1];
  assign bus.req0_op_1_re   = op_d[0].a_re;
  assign bus.req0_op_1_im   = op_d[0].a_im;
  assign bus.req0_op_2_re   = op_d[0].b_re;
  assign bus.req0_op_2_im   = op_d[0].b_im;
  assign bus.req1_op_1_re   = op_d[1].a_re;
  assign bus.req1_op_1_im   = op_d[1].a_im;
  assign bus.req1_op_2_re   = op_d[1].b_re;
  assign bus.req1_op_2_im   = op_d[1].b_im;
  assign bus.req0_res_ready = res_rdy[0];
  assign bus.req1_res_ready = res_rdy[1];
  assign op_rdy[0]  = bus.req0_op_ready;
  assign op_rdy[1]  = bus.req1_op_ready;
  assign res_val[0] = bus.req0_res_val;
  assign res_val[1] = bus.req1_res_val;
  assign res_re[0]  = bus.req0_res_re;
  assign res_im[0]  = bus.req0_res_im;
  assign res_re[1]  = bus.req1_res_re;
  assign res_im[1]  = bus.req1_res_im;

  // Multiplier side
  logic m_op_rdy = 1'b0;
  logic m_res_v  = 1'b0;
  res_t m_res    = '0;
  assign bus.m_op_ready = m_op_rdy;
  assign bus.m_res_val  = m_res_v;
  assign bus.m_res_re   = m_res.re;
  assign bus.m_res_im   = m_res.im;

  // Shared state / knobs
  op_t  req_q [2][$];
  res_t exp_q [2][$];
  int   grant_log [$];
  bit   fired [2]     = '{0, 0};
  int   acc_cyc [2]   = '{0, 0};
  int   delivered [2] = '{0, 0};
  int   first_acc_cyc = -1;
  int   cyc;
  bit   rnd_ready = 0, mul_stall = 0, mul_rand = 0, lat_chk = 0;
  logic [1:0] res_hold = 2'b00;
  int   mul_lat = 1, lat_exp = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Requester drivers: present queued operations, log each accepted one
  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (fired[n]) begin
        op_val[n] = 1'b0;
        fired[n]  = 1'b0;
      end
      if (!op_val[n] && req_q[n].size() > 0) begin
        op_d[n]   = req_q[n].pop_front();
        op_val[n] = 1'b1;
      end
    end
    #1;
    for (int n = 0; n < 2; n++) begin
      if (op_val[n] && op_rdy[n]) begin
        fired[n] = 1'b1;
        exp_q[n].push_back(cmul(op_d[n]));
        acc_cyc[n] = cyc;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        grant_log.push_back(n);
      end
    end
  end

  // Result monitor: drives res_ready, pops and compares on each delivery
  always @(negedge clk) begin
    res_t e;
    for (int n = 0; n < 2; n++)
      res_rdy[n] = res_hold[n] ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    #1;
    if (res_val != 2'b00) check("res_val_onehot", longint'(res_val[0] & res_val[1]), 0);
    for (int n = 0; n < 2; n++) begin
      if (res_val[n] && res_rdy[n]) begin
        if (exp_q[n].size() == 0) begin
          check($sformatf("res%0d_unexpected", n), 1, 0);
        end else begin
          e = exp_q[n].pop_front();
          check($sformatf("res%0d_re", n), $signed(res_re[n]), e.re);
          check($sformatf("res%0d_im", n), $signed(res_im[n]), e.im);
          if (lat_chk) check("latency", cyc - acc_cyc[n], lat_exp);
          delivered[n]++;
        end
      end
    end
  end

  // Behavioural shared multiplier with configurable latency and stalls
  op_t mop = '0;
  bit  mop_fire = 0, mres_fire = 0, mpend = 0;
  int  mcnt = 0;
  always @(negedge clk) begin
    if (mres_fire) m_res_v = 1'b0;
    if (mop_fire) begin
      m_res = cmul(mop);
      mcnt  = (mul_rand ? int'($urandom_range(1, 3)) : mul_lat) - 1;
      mpend = 1'b1;
    end else if (mpend && mcnt > 0) begin
      mcnt = mcnt - 1;
    end
    if (mpend && mcnt == 0) begin
      m_res_v = 1'b1;
      mpend   = 1'b0;
    end
    m_op_rdy = mul_stall ? 1'b0 : (mul_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    #1;
    if (rst || bus.m_sw_rst) begin
      m_res_v = 1'b0; mpend = 1'b0; mop_fire = 1'b0; mres_fire = 1'b0;
    end else begin
      mop_fire  = bus.m_op_val && m_op_rdy;
      mres_fire = m_res_v && bus.m_res_ready;
      mop.a_re = bus.m_op_1_re; mop.a_im = bus.m_op_1_im;
      mop.b_re = bus.m_op_2_re; mop.b_im = bus.m_op_2_im;
    end
  end

  task automatic drain(input string name, input int maxc);
    int k = 0;
    while (!(req_q[0].size() == 0 && req_q[1].size() == 0 && op_val == 2'b00 &&
             exp_q[0].size() == 0 && exp_q[1].size() == 0 && !bus.busy) && k < maxc) begin
      @(negedge clk); #2; k++;
    end
    check(name, (k < maxc) ? 1 : 0, 1);
  endtask

`ifdef CMUL_ARB_FIXED_PRIO_EN
  int pair_order [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
  int pair_order [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif

  initial begin
    op_t  o, o2;
    res_t e;
    int   k, base0, base1;

    // Reset, with both requesters already presenting operations
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_q[0].push_back(rand_op());
      req_q[1].push_back(i == 0 ? mk_op(1, 1, 1, -1) : rand_op());
    end
    @(negedge clk); #2;
    check("rst_ctrl", {bus.busy, bus.grant_id, bus.m_op_val, bus.m_res_ready,
                       bus.req0_res_val, bus.req1_res_val, bus.req0_op_ready, bus.req1_op_ready}, 0);
    check("rst_m_ops", {bus.m_op_1_re, bus.m_op_1_im, bus.m_op_2_re, bus.m_op_2_im}, 0);
    check("rst_res_data", longint'(|{bus.req0_res_re, bus.req0_res_im, bus.req1_res_re, bus.req1_res_im}), 0);
    check("rst_m_sw_rst", bus.m_sw_rst, 0);
    @(negedge clk);
    rst = 1'b0;

    // Both requesters valid from the first cycle: grant order
    k = 0;
    while ((delivered[0] < 4 || delivered[1] < 4) && k < 400) begin
      @(negedge clk); #2; k++;
    end
    check("pair_done", (k < 400) ? 1 : 0, 1);
    check("first_grant_cycle", first_acc_cyc, 0);
    check("pair_grants", grant_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < grant_log.size()) check($sformatf("pair_grant%0d", i), grant_log[i], pair_order[i]);
    drain("pair_drain", 100);

    // Single request, directed value and end-to-end latency
    grant_log.delete();
    mul_lat = 2; lat_exp = 4; lat_chk = 1;
    req_q[0].push_back(mk_op(2, 4, 3, 4));
    k = 0;
    while (!bus.req0_res_val && k < 60) begin @(negedge clk); #2; k++; end
    check("single_res_val", bus.req0_res_val, 1);
    check("single_grant_id", bus.grant_id, 0);
    check("single_re", $signed(bus.req0_res_re), -10);
    check("single_im", $signed(bus.req0_res_im), 20);
    drain("single_drain", 60);
    lat_chk = 0; mul_lat = 1;

    // Multiplier stalls in ISSUE: operands held, no new grants
    mul_stall = 1;
    o = rand_op();
    req_q[0].push_back(o);
    k = 0;
    while (!bus.busy && k < 20) begin @(negedge clk); #2; k++; end
    req_q[1].push_back(rand_op());
    k = 0;
    while (!bus.m_op_val && k < 20) begin @(negedge clk); #2; k++; end
    @(negedge clk); #2;
    for (int i = 0; i < 5; i++) begin
      check("stall_m_op_val", bus.m_op_val, 1);
      check("stall_ops", {bus.m_op_1_re, bus.m_op_1_im, bus.m_op_2_re, bus.m_op_2_im}, o);
      check("stall_op_ready", {bus.req0_op_ready, bus.req1_op_ready}, 0);
      @(negedge clk); #2;
    end
    mul_stall = 0;
    drain("stall_drain", 100);

    // Requester 0 holds off its result while requester 1 waits
    grant_log.delete();
    res_hold[0] = 1'b1;
    o = rand_op();
    req_q[0].push_back(o);
    k = 0;
    while (!bus.busy && k < 20) begin @(negedge clk); #2; k++; end
    req_q[1].push_back(rand_op());
    k = 0;
    while (!bus.req0_res_val && k < 40) begin @(negedge clk); #2; k++; end
    e = cmul(o);
    for (int i = 0; i < 7; i++) begin
      check("hold_res_val", bus.req0_res_val, 1);
      check("hold_re", $signed(bus.req0_res_re), e.re);
      check("hold_im", $signed(bus.req0_res_im), e.im);
      check("hold_req1_ready", bus.req1_op_ready, 0);
      @(negedge clk); #2;
    end
    res_hold[0] = 1'b0;
    drain("hold_drain", 100);
    check("hold_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) check("hold_second_grant", grant_log[1], 1);

    // Software reset while waiting for the multiplier result
    mul_lat = 6;
    req_q[0].push_back(rand_op());
    k = 0;
    while (!bus.m_res_ready && k < 40) begin @(negedge clk); #2; k++; end
    check("swrst_in_wait", bus.m_res_ready, 1);
    @(negedge clk);
    sw = 1'b1;
    #2;
    check("swrst_m_sw_rst", bus.m_sw_rst, 1);
    @(negedge clk);
    sw = 1'b0;
    exp_q[0].delete();
    #2;
    check("swrst_idle", {bus.busy, bus.m_op_val, bus.m_res_ready, bus.req0_res_val, bus.req1_res_val}, 0);
    check("swrst_m_sw_rst_low", bus.m_sw_rst, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #2;
      check("swrst_no_res", {bus.req0_res_val, bus.req1_res_val}, 0);
    end
    mul_lat = 1;
    req_q[1].push_back(mk_op(2, 0, 0, 3));
    k = 0;
    while (!bus.req1_res_val && k < 40) begin @(negedge clk); #2; k++; end
    check("swrst_after_re", $signed(bus.req1_res_re), 0);
    check("swrst_after_im", $signed(bus.req1_res_im), 6);
    drain("swrst_drain", 60);

    // Asynchronous reset in the middle of ISSUE
    mul_stall = 1;
    req_q[0].push_back(rand_op());
    k = 0;
    while (!bus.m_op_val && k < 20) begin @(negedge clk); #2; k++; end
    req_q[1].push_back(rand_op());
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_outputs", {bus.m_op_val, bus.busy, bus.m_res_ready, bus.req0_res_val,
                           bus.req1_res_val, bus.req0_op_ready, bus.req1_op_ready, bus.grant_id}, 0);
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge clk);
    rst = 1'b0;
    mul_stall = 0;
    drain("arst_drain", 100);

    // Random traffic with random stalls on every handshake
    rnd_ready = 1; mul_rand = 1;
    base0 = delivered[0]; base1 = delivered[1];
    for (int i = 0; i < 25; i++) begin
      req_q[0].push_back(rand_op());
      req_q[1].push_back(rand_op());
    end
    drain("rand_drain", 4000);
    check("rand_count0", delivered[0] - base0, 25);
    check("rand_count1", delivered[1] - base1, 25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
